mem_wb_stage: RTL and testbench

- Memory-stage engine that consumes the EX/M pipeline register outputs and drives the synchronous data-memory port.
- Resolves multi-cycle loads by stalling upstream.
- Registers the result into the M/WB pipeline outputs that feed register-file writeback.
- Sits between the EX/M register and the writeback mux / register file.

---
 rtl/mem_wb_stage.sv | 126 ++++++++++++
 tb/tb_mem_wb_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory stage: drives the data-memory port and registers results into M/WB; non-loads take 1 cycle, loads DMEM_LAT+1.
// Backpressure: stall_M holds EX/M and earlier stages while a load is outstanding; stall_M never depends on dmem_rdata.
module mem_wb_stage #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 8,
  parameter int DMEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              NOOP_M,
  input  logic              LW_M,
  input  logic              SW_M,
  input  logic              WME_M,
  input  logic              WRE_M,
  input  logic [DATA_W-1:0] ALU_result_M,
  input  logic [DATA_W-1:0] rt_data_M,
  input  logic [4:0]        rt_M,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  output logic              dmem_re,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_M,
  output logic              valid_WB,
  output logic              WRE_WB,
  output logic              LW_WB,
  output logic [4:0]        rt_WB,
  output logic [DATA_W-1:0] wb_data_WB
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(DMEM_LAT - 1);
  localparam state_t     LD_NEXT  = (DMEM_LAT > 1) ? WAIT : DONE;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                wre_q, wre_d;
  logic                lw_q, lw_d;
  logic [4:0]          rt_q, rt_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic act;
  logic ld_m;
  logic idle;

  assign act  = ~NOOP_M & (LW_M | SW_M | WRE_M);
  assign ld_m = LW_M & ~NOOP_M;
  assign idle = (state_q == IDLE);

  assign dmem_addr  = ALU_result_M[ADDR_W-1:0];
  assign dmem_wdata = rt_data_M;

  // Strobes only fire from IDLE so a held load is never re-issued; rst gating drops them during reset.
  assign dmem_we = rst & idle & SW_M & WME_M & ~NOOP_M & ~LW_M;
  assign dmem_re = rst & idle & ld_m;
  assign stall_M = rst & ((idle & ld_m) | (state_q == WAIT));

  assign valid_WB   = valid_q;
  assign WRE_WB     = wre_q;
  assign LW_WB      = lw_q;
  assign rt_WB      = rt_q;
  assign wb_data_WB = data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    wre_d   = 1'b0;
    lw_d    = 1'b0;
    rt_d    = rt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (ld_m) begin
          state_d = LD_NEXT;
          cnt_d   = CNT_INIT;
        end else begin
          valid_d = act;
          wre_d   = WRE_M & ~NOOP_M;
          rt_d    = rt_M;
          data_d  = ALU_result_M;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = DONE;
      end
      DONE: begin
        valid_d = 1'b1;
        wre_d   = WRE_M;
        lw_d    = 1'b1;
        rt_d    = rt_M;
        data_d  = dmem_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      wre_q   <= 1'b0;
      lw_q    <= 1'b0;
      rt_q    <= 5'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wre_q   <= wre_d;
      lw_q    <= lw_d;
      rt_q    <= rt_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed plan steps then random instructions, checked per instruction
// against a reference memory and the stage's cycle-level timing rules.
module tb_mem_wb_stage;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 8;
  localparam int DMEM_LAT = 2;
  localparam logic [63:0] STALE = 64'hBADB_ADBA_DBAD_BAD0;

  logic              clk = 1'b0;
  logic              rst;
  logic              NOOP_M, LW_M, SW_M, WME_M, WRE_M;
  logic [DATA_W-1:0] ALU_result_M, rt_data_M;
  logic [4:0]        rt_M;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata, dmem_rdata;
  logic              dmem_we, dmem_re, stall_M;
  logic              valid_WB, WRE_WB, LW_WB;
  logic [4:0]        rt_WB;
  logic [DATA_W-1:0] wb_data_WB;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mem     [256];
  logic [63:0] ref_mem [256];
  logic [63:0] rd_pipe [DMEM_LAT];

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DMEM_LAT(DMEM_LAT)) dut (
    .clk(clk), .rst(rst), .NOOP_M(NOOP_M), .LW_M(LW_M), .SW_M(SW_M), .WME_M(WME_M),
    .WRE_M(WRE_M), .ALU_result_M(ALU_result_M), .rt_data_M(rt_data_M), .rt_M(rt_M),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_re(dmem_re),
    .dmem_rdata(dmem_rdata), .stall_M(stall_M), .valid_WB(valid_WB), .WRE_WB(WRE_WB),
    .LW_WB(LW_WB), .rt_WB(rt_WB), .wb_data_WB(wb_data_WB)
  );

  // Synchronous memory: data for a read strobe appears DMEM_LAT cycles later, otherwise stale junk.
  assign dmem_rdata = rd_pipe[DMEM_LAT-1];
  always @(posedge clk) begin
    for (int i = DMEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= dmem_re ? mem[dmem_addr] : STALE;
    if (dmem_we) mem[dmem_addr] <= dmem_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic noop, lw, sw, wme, wre,
                       input logic [63:0] alu, wd, input logic [4:0] rt);
    NOOP_M = noop; LW_M = lw; SW_M = sw; WME_M = wme; WRE_M = wre;
    ALU_result_M = alu; rt_data_M = wd; rt_M = rt;
  endtask

  // Presents one instruction (entered #1 after an edge) and holds it until it leaves M.
  task automatic run_instr(input string nm, input logic noop, lw, sw, wme, wre,
                           input logic [63:0] alu, wd, input logic [4:0] rt);
    logic        ld, act, st;
    logic [7:0]  a;
    logic [63:0] exp_data;
    ld  = lw & ~noop;
    act = ~noop & (lw | sw | wre);
    st  = sw & wme & ~noop & ~lw;
    a   = alu[7:0];
    drive(noop, lw, sw, wme, wre, alu, wd, rt);
    #3;
    chk({nm, ".addr"},  64'(dmem_addr), 64'(a));
    chk({nm, ".wdata"}, dmem_wdata, wd);
    chk({nm, ".we"},    64'(dmem_we), 64'(st));
    chk({nm, ".re"},    64'(dmem_re), 64'(ld));
    chk({nm, ".stall"}, 64'(stall_M), 64'(ld));
    if (!ld) begin
      if (st) ref_mem[a] = wd;
      @(posedge clk); #1;
      chk({nm, ".valid"}, 64'(valid_WB), 64'(act));
      chk({nm, ".wre"},   64'(WRE_WB), 64'(wre & ~noop));
      chk({nm, ".lw"},    64'(LW_WB), 64'd0);
      chk({nm, ".rt"},    64'(rt_WB), 64'(rt));
      chk({nm, ".data"},  wb_data_WB, alu);
      chk({nm, ".stall_after"}, 64'(stall_M), 64'(1'b0));
    end else begin
      exp_data = ref_mem[a];
      for (int k = 1; k <= DMEM_LAT; k++) begin
        @(posedge clk); #1;
        chk({nm, ".hold_stall"}, 64'(stall_M), 64'(k < DMEM_LAT));
        chk({nm, ".hold_re"},    64'(dmem_re), 64'd0);
        chk({nm, ".hold_we"},    64'(dmem_we), 64'd0);
        chk({nm, ".hold_valid"}, 64'(valid_WB), 64'd0);
      end
      @(posedge clk); #1;
      chk({nm, ".ld_valid"}, 64'(valid_WB), 64'd1);
      chk({nm, ".ld_wre"},   64'(WRE_WB), 64'(wre));
      chk({nm, ".ld_lw"},    64'(LW_WB), 64'd1);
      chk({nm, ".ld_rt"},    64'(rt_WB), 64'(rt));
      chk({nm, ".ld_data"},  wb_data_WB, exp_data);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ".stall"}, 64'(stall_M), 64'd0);
    chk({nm, ".re"},    64'(dmem_re), 64'd0);
    chk({nm, ".we"},    64'(dmem_we), 64'd0);
    chk({nm, ".valid"}, 64'(valid_WB), 64'd0);
    chk({nm, ".wre"},   64'(WRE_WB), 64'd0);
    chk({nm, ".lw"},    64'(LW_WB), 64'd0);
    chk({nm, ".rt"},    64'(rt_WB), 64'd0);
    chk({nm, ".data"},  wb_data_WB, 64'd0);
  endtask

  initial begin
    logic        r_noop, r_lw, r_sw, r_wme, r_wre;
    logic [63:0] r_alu, r_wd;
    logic [4:0]  r_rt;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = {$urandom(), $urandom()};
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < DMEM_LAT; i++) rd_pipe[i] = STALE;

    // Reset held for two cycles with a register-write presented.
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 5'd3);
    repeat (2) begin
      @(posedge clk); #1;
      chk_reset_outputs("reset");
    end
    rst = 1'b1;
    run_instr("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 5'd3);

    run_instr("regop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd9, 64'd0, 5'd1);
    run_instr("store", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h10, 64'hDEAD, 5'd0);
    run_instr("load",  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h10, 64'd0, 5'd2);
    chk("load.literal", wb_data_WB, 64'hDEAD);
    run_instr("noop",  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h20, 64'h55, 5'd4);
    run_instr("idle_bubble", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h21, 64'h66, 5'd5);
    run_instr("sw_lw", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h10, 64'h1234, 5'd6);
    chk("sw_lw.unchanged", wb_data_WB, 64'hDEAD);

    // Reset during the wait phase of a load, then the same load is reissued.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h10, 64'd0, 5'd7);
    @(posedge clk); #1;
    chk("midload.stall_before", 64'(stall_M), 64'd1);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midload_rst");
    @(posedge clk); #1;
    chk_reset_outputs("midload_hold");
    rst = 1'b1;
    run_instr("midload_retry", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h10, 64'd0, 5'd7);

    for (int n = 0; n < 150; n++) begin
      r_noop = ($urandom_range(0, 7) == 0);
      r_lw   = ($urandom_range(0, 3) == 0);
      r_sw   = ($urandom_range(0, 2) == 0);
      r_wme  = ($urandom_range(0, 3) != 0);
      r_wre  = $urandom_range(0, 1) == 1;
      r_alu  = {$urandom(), $urandom()};
      r_alu[7:0] = 8'($urandom_range(0, 15));
      r_wd   = {$urandom(), $urandom()};
      r_rt   = 5'($urandom_range(0, 31));
      run_instr("rand", r_noop, r_lw, r_sw, r_wme, r_wre, r_alu, r_wd, r_rt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
